// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// The optional FETCH_PERF_EN macro (see riscv_fetch_unit) adds performance counters.
package riscv_fetch_pkg;

  localparam int INSTR_W = 32;
  // Width of the PC field stored in the prefetch buffer; the unit supports ADDR_W up to this.
  localparam int FETCH_ADDR_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Circular prefetch buffer of fetch_entry_t. Flush has priority over push and pop.
// Push while full is accepted only when a pop happens in the same cycle.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = entries_q[rd_ptr_q];

  // Pointer and occupancy update; flush empties the buffer regardless of push/pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entries_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential word requests,
// buffers in-order responses with their PCs and hands them to the core.
// A redirect flushes the buffer and drops responses still in flight.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
// Handshakes: a transfer happens on a cycle where valid && ready are both high at the
// rising edge; a producer holds its payload stable while valid && !ready.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_drop_cnt
`endif
);

  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;

  logic [CNT_W:0]    credit_used;
  logic              req_fire;
  logic              rsp_live;
  logic              rsp_drop_hit;
  logic [ADDR_W-1:0] redirect_target;

  // Request credit: outstanding requests plus buffered words may never exceed DEPTH,
  // so every live response is guaranteed a free FIFO slot.
  always_comb begin
    credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req_valid  = reset && !redirect_valid && !fifo_full &&
                      (credit_used < (CNT_W + 1)'(DEPTH));
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_live        = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    rsp_drop_hit    = imem_rsp_valid && !redirect_valid && (drop_cnt_q != '0);
    redirect_target = redirect_pc & ALIGN_MASK;
    push_entry      = '{instr: imem_rsp_data, pc: FETCH_ADDR_W'(rsp_pc_q)};
  end

  // Next-state for PCs and counters; redirect overrides sequential progress.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire)     fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_live)     rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (rsp_drop_hit) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (rsp_live),
    .push_data (push_entry),
    .pop       (instr_valid && instr_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Core-facing view of the FIFO head; idle outputs show zero data and the next expected PC.
  always_comb begin
    imem_req_addr = fetch_pc_q;
    instr_valid   = !fifo_empty;
    instr_data    = fifo_empty ? '0 : fifo_head.instr;
    instr_pc      = fifo_empty ? rsp_pc_q : ADDR_W'(fifo_head.pc);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_drop_q, perf_drop_d;
  logic        rsp_discard;

  // Saturating counts of pushed and discarded responses (redirect-cycle beats are discards).
  always_comb begin
    rsp_discard  = imem_rsp_valid && !rsp_live;
    perf_fetch_d = perf_fetch_q;
    perf_drop_d  = perf_drop_q;
    if (rsp_live && (perf_fetch_q != 32'hFFFF_FFFF))   perf_fetch_d = perf_fetch_q + 32'd1;
    if (rsp_discard && (perf_drop_q != 32'hFFFF_FFFF)) perf_drop_d  = perf_drop_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: in-order memory model with random latency,
// queue-based reference model of the fetch stream, directed scenarios and random traffic.
module tb_riscv_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  riscv_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model: expected FIFO contents {instr, pc}, PCs and in-flight bookkeeping.
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch, m_rsp;
  int          m_out, m_drop;
  logic [31:0] m_perf_fetch, m_perf_drop;

  // Memory model: in-order pending requests with the cycle each may respond.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;

  // Stimulus knobs.
  int          k_req_pct = 100, k_ir_pct = 100, k_redir_pm = 0;
  bit          dir_redirect = 1'b0;
  logic [31:0] dir_pc = '0;
  bit          release_req = 1'b0;

  // Logs for directed checks.
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  int          dlv_cyc[$];
  int          lc = 0;

  // Per-cycle captures.
  bit          c_req_valid, c_req_fire, c_pop, c_iv;
  logic [31:0] c_addr, c_ipc;
  bit          p_stall = 1'b0;
  logic [31:0] p_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch      = RESET_PC;
    m_rsp        = RESET_PC;
    m_out        = 0;
    m_drop       = 0;
    m_perf_fetch = '0;
    m_perf_drop  = '0;
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    p_stall      = 1'b0;
  endtask

  // The single compare point: all DUT outputs against the model.
  task automatic check_outputs();
    bit exp_rv;
    if (!reset) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr_data", instr_data, 0);
      check("rst_instr_pc", instr_pc, RESET_PC);
      check("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_EN
      check("rst_perf_fetch", perf_fetch_cnt, 0);
      check("rst_perf_drop", perf_drop_cnt, 0);
`endif
    end else begin
      exp_rv = ((m_out + exp_q.size()) < DEPTH) && !redirect_valid;
      check("req_valid", imem_req_valid, exp_rv);
      check("req_addr", imem_req_addr, m_fetch);
      check("instr_valid", instr_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("instr_data", instr_data, exp_q[0][63:32]);
        check("instr_pc", instr_pc, exp_q[0][31:0]);
      end
      if (p_stall && imem_req_valid) check("addr_stable", imem_req_addr, p_addr);
`ifdef FETCH_PERF_EN
      check("perf_fetch", perf_fetch_cnt, m_perf_fetch);
      check("perf_drop", perf_drop_cnt, m_perf_drop);
`endif
    end
  endtask

  // Advance the model by one clock edge using the inputs that were presented.
  task automatic model_update();
    bit rsp;
    bit pop;
    rsp = imem_rsp_valid;
    if (redirect_valid) begin
      m_out   = m_out - (rsp ? 1 : 0);
      m_drop  = m_out;
      exp_q.delete();
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
      m_rsp   = m_fetch;
      if (rsp) m_perf_drop = sat_inc(m_perf_drop);
    end else begin
      pop = (exp_q.size() > 0) && instr_ready;
      if (pop) void'(exp_q.pop_front());
      if (c_req_fire) begin
        m_fetch = m_fetch + 32'd4;
        m_out++;
      end
      if (rsp) begin
        m_out--;
        if (m_drop > 0) begin
          m_drop--;
          m_perf_drop = sat_inc(m_perf_drop);
        end else begin
          exp_q.push_back({mem_word(m_rsp), m_rsp});
          m_rsp        = m_rsp + 32'd4;
          m_perf_fetch = sat_inc(m_perf_fetch);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clk);
    if (release_req) begin
      reset       = 1'b1;
      release_req = 1'b0;
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < k_req_pct);
    instr_ready    = ($urandom_range(99) < k_ir_pct);
    if (dir_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = dir_pc;
      dir_redirect   = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(999) < k_redir_pm);
      redirect_pc    = rand_pc();
    end
    #1;
    check_outputs();
    c_req_valid = imem_req_valid;
    c_req_fire  = imem_req_valid && imem_req_ready;
    c_addr      = imem_req_addr;
    c_iv        = instr_valid;
    c_pop       = instr_valid && instr_ready && !redirect_valid;
    c_ipc       = instr_pc;
    if (c_req_fire) req_log.push_back(c_addr);
    if (c_pop) begin
      dlv_pc.push_back(c_ipc);
      dlv_cyc.push_back(lc);
    end
    @(posedge clk);
    cyc++;
    lc++;
    model_update();
    if (c_req_fire) begin
      pend_addr.push_back(c_addr);
      pend_due.push_back(cyc + $urandom_range(lat_max, lat_min) - 1);
    end
    p_stall = c_req_valid && !imem_req_ready;
    p_addr  = c_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset asserted between clock edges; released at the next driven cycle.
  task automatic hold_reset(input int n);
    @(negedge clk);
    #3;
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check_outputs();
    end
    req_log.delete();
    dlv_pc.delete();
    dlv_cyc.delete();
    lc          = 0;
    release_req = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #2 reset = 1'b0;

    // Streaming from reset: memory always ready, latency 1, core always ready.
    k_req_pct = 100; k_ir_pct = 100; k_redir_pm = 0; lat_min = 1; lat_max = 1;
    hold_reset(2);
    run(12);
    check("t1_req0", q_at(req_log, 0), 32'h0);
    check("t1_req1", q_at(req_log, 1), 32'h4);
    check("t1_req2", q_at(req_log, 2), 32'h8);
    check("t1_dlv0", q_at(dlv_pc, 0), 32'h0);
    check("t1_dlv1", q_at(dlv_pc, 1), 32'h4);
    check("t1_dlv2", q_at(dlv_pc, 2), 32'h8);
    check("t1_first_cycle", (dlv_cyc.size() > 0) ? dlv_cyc[0] : -1, 2);

    // Core stalled for 10 cycles: only DEPTH requests, then drain in order.
    hold_reset(2);
    k_ir_pct = 0;
    run(10);
    check("t2_req_count", req_log.size(), 2);
    check("t2_req_valid_low", c_req_valid, 0);
    check("t2_head_pc", c_ipc, 32'h0);
    k_ir_pct = 100;
    run(8);
    check("t2_dlv0", q_at(dlv_pc, 0), 32'h0);
    check("t2_dlv1", q_at(dlv_pc, 1), 32'h4);
    check("t2_resume", q_at(req_log, 2), 32'h8);

    // Redirect to 0x100 with two requests outstanding.
    hold_reset(2);
    k_ir_pct = 0; lat_min = 4; lat_max = 4;
    run(2);
    dir_redirect = 1'b1; dir_pc = 32'h100; k_ir_pct = 100; lat_min = 1; lat_max = 1;
    cycle();
    cycle();
    check("t3_no_credit", c_req_valid, 0);
    run(12);
    check("t3_req_target", q_at(req_log, 2), 32'h100);
    check("t3_dlv0", q_at(dlv_pc, 0), 32'h100);
    check("t3_dlv1", q_at(dlv_pc, 1), 32'h104);

    // Redirect to unaligned 0x203 in the same cycle as a response and a pop.
    hold_reset(2);
    run(2);
    dir_redirect = 1'b1; dir_pc = 32'h203;
    cycle();
    check("t4_head_valid", c_iv, 1);
    run(10);
    check("t4_req_target", q_at(req_log, 2), 32'h200);
    check("t4_dlv0", q_at(dlv_pc, 0), 32'h200);
    check("t4_dlv1", q_at(dlv_pc, 1), 32'h204);

    // Memory not ready for 5 cycles: address held, one increment per handshake.
    hold_reset(2);
    k_req_pct = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_hold_addr", c_addr, 32'h0);
      check("t5_hold_valid", c_req_valid, 1);
    end
    k_req_pct = 100;
    run(6);
    check("t5_req0", q_at(req_log, 0), 32'h0);
    check("t5_req1", q_at(req_log, 1), 32'h4);
    check("t5_dlv0", q_at(dlv_pc, 0), 32'h0);

    // Random traffic, each block entered through a mid-stream asynchronous reset.
    for (int blk = 0; blk < 6; blk++) begin
      hold_reset(2);
      k_req_pct  = $urandom_range(100, 30);
      k_ir_pct   = $urandom_range(100, 20);
      k_redir_pm = $urandom_range(80, 0);
      lat_min    = 1;
      lat_max    = $urandom_range(4, 1);
      run(400);
      check("restart_addr", q_at(req_log, 0), RESET_PC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
